// File: rtl/exe_pkg.sv
// Shared constants for the CAP19 execute stage: widths, ALU command encodings
// and forwarding-select values.
package exe_pkg;

    localparam int WORD_LEN = 32;
    localparam int SEL_LEN  = 2;
    localparam int CMD_LEN  = 4;

    typedef enum logic [CMD_LEN-1:0] {
        EXE_ADD  = 4'b0000,
        EXE_SUB  = 4'b0010,
        EXE_AND  = 4'b0100,
        EXE_OR   = 4'b0101,
        EXE_NOR  = 4'b0110,
        EXE_XOR  = 4'b0111,
        EXE_SLL  = 4'b1000,
        EXE_SRA  = 4'b1001,
        EXE_SRL  = 4'b1010,
        EXE_SLLV = 4'b1011,
        EXE_SLT  = 4'b1100,
        EXE_NOP  = 4'b1111
    } exe_cmd_e;

    localparam logic [SEL_LEN-1:0] FWD_IDEX = 2'd0;
    localparam logic [SEL_LEN-1:0] FWD_MEM  = 2'd1;
    localparam logic [SEL_LEN-1:0] FWD_WB   = 2'd2;

endpackage

// File: rtl/fwd_mux3.sv
// Forwarding select: ID/EX value, EX/MEM ALU result or WB result; the unused
// select code yields zero.
module fwd_mux3
    import exe_pkg::*;
#(
    parameter int LENGTH = 32
) (
    input  logic [SEL_LEN-1:0] sel,
    input  logic [LENGTH-1:0]  idex_val,
    input  logic [LENGTH-1:0]  mem_val,
    input  logic [LENGTH-1:0]  wb_val,
    output logic [LENGTH-1:0]  out_val
);

    always_comb begin
        // NOTE: default assignment first so every path drives out_val and no latch is inferred.
        out_val = '0;
        case (sel)
            FWD_IDEX: out_val = idex_val;
            FWD_MEM:  out_val = mem_val;
            FWD_WB:   out_val = wb_val;
            default:  out_val = '0;
        endcase
    end

endmodule

// File: rtl/exe_alu.sv
// CAP19 execute stage: operand/store forwarding, 32-bit ALU, EX/MEM result registers.
// Optional ALU_FLAGS_EN adds registered zero/negative/overflow flags.
module exe_alu
    import exe_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic [CMD_LEN-1:0]  exe_cmd,
    input  logic [SEL_LEN-1:0]  val1_sel,
    input  logic [SEL_LEN-1:0]  val2_sel,
    input  logic [SEL_LEN-1:0]  st_val_sel,
    input  logic [WORD_LEN-1:0] val1,
    input  logic [WORD_LEN-1:0] val2,
    input  logic [WORD_LEN-1:0] st_value_in,
    input  logic [WORD_LEN-1:0] alu_res_mem,
    input  logic [WORD_LEN-1:0] result_wb,
    input  logic [7:0]          shamt,
    output logic [WORD_LEN-1:0] alu_result,
    output logic [WORD_LEN-1:0] st_value_out
`ifdef ALU_FLAGS_EN
    ,
    output logic                zero_flag,
    output logic                neg_flag,
    output logic                ovf_flag
`endif
);

    logic [WORD_LEN-1:0] op_a;
    logic [WORD_LEN-1:0] op_b;
    logic [WORD_LEN-1:0] st_fwd;
    logic [WORD_LEN-1:0] sum;
    logic [WORD_LEN-1:0] diff;
    logic [WORD_LEN-1:0] alu_next;
    logic [4:0]          sh_imm;
    logic                shamt_unused;

    fwd_mux3 #(.LENGTH(WORD_LEN)) u_mux_a (
        .sel      (val1_sel),
        .idex_val (val1),
        .mem_val  (alu_res_mem),
        .wb_val   (result_wb),
        .out_val  (op_a)
    );

    fwd_mux3 #(.LENGTH(WORD_LEN)) u_mux_b (
        .sel      (val2_sel),
        .idex_val (val2),
        .mem_val  (alu_res_mem),
        .wb_val   (result_wb),
        .out_val  (op_b)
    );

    fwd_mux3 #(.LENGTH(WORD_LEN)) u_mux_st (
        .sel      (st_val_sel),
        .idex_val (st_value_in),
        .mem_val  (alu_res_mem),
        .wb_val   (result_wb),
        .out_val  (st_fwd)
    );

    // Shift amounts wrap mod 32; the upper immediate bits carry no meaning.
    assign sh_imm       = shamt[4:0];
    assign shamt_unused = ^shamt[7:5];
    assign sum          = op_a + op_b;
    assign diff         = op_a - op_b;

    always_comb begin
        alu_next = '0;
        case (exe_cmd_e'(exe_cmd))
            EXE_ADD:  alu_next = sum;
            EXE_SUB:  alu_next = diff;
            EXE_AND:  alu_next = op_a & op_b;
            EXE_OR:   alu_next = op_a | op_b;
            EXE_NOR:  alu_next = ~(op_a | op_b);
            EXE_XOR:  alu_next = op_a ^ op_b;
            EXE_SLL:  alu_next = op_b << sh_imm;
            EXE_SRA:  alu_next = $signed(op_b) >>> sh_imm;
            EXE_SRL:  alu_next = op_b >> sh_imm;
            EXE_SLLV: alu_next = op_a << op_b[4:0];
            EXE_SLT:  alu_next = {{(WORD_LEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            default:  alu_next = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; async reset clears outputs without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result   <= '0;
            st_value_out <= '0;
        end else if (!stall) begin
            alu_result   <= alu_next;
            st_value_out <= st_fwd;
        end
    end

`ifdef ALU_FLAGS_EN
    logic ovf_next;

    always_comb begin
        ovf_next = 1'b0;
        case (exe_cmd_e'(exe_cmd))
            EXE_ADD: ovf_next = (op_a[WORD_LEN-1] == op_b[WORD_LEN-1]) &&
                                (sum[WORD_LEN-1] != op_a[WORD_LEN-1]);
            EXE_SUB: ovf_next = (op_a[WORD_LEN-1] != op_b[WORD_LEN-1]) &&
                                (diff[WORD_LEN-1] != op_a[WORD_LEN-1]);
            default: ovf_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
            ovf_flag  <= 1'b0;
        end else if (!stall) begin
            zero_flag <= (alu_next == '0);
            neg_flag  <= alu_next[WORD_LEN-1];
            ovf_flag  <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_exe_alu.sv
// Scoreboard bench for exe_alu: a driver pushes hand-computed expectations,
// a monitor pops and compares one cycle later. Honors ALU_FLAGS_EN.
module tb_exe_alu;
    import exe_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                stall;
    logic [CMD_LEN-1:0]  exe_cmd;
    logic [SEL_LEN-1:0]  val1_sel, val2_sel, st_val_sel;
    logic [WORD_LEN-1:0] val1, val2, st_value_in, alu_res_mem, result_wb;
    logic [7:0]          shamt;
    logic [WORD_LEN-1:0] alu_result, st_value_out;
`ifdef ALU_FLAGS_EN
    logic                zero_flag, neg_flag, ovf_flag;
`endif

    exe_alu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .exe_cmd      (exe_cmd),
        .val1_sel     (val1_sel),
        .val2_sel     (val2_sel),
        .st_val_sel   (st_val_sel),
        .val1         (val1),
        .val2         (val2),
        .st_value_in  (st_value_in),
        .alu_res_mem  (alu_res_mem),
        .result_wb    (result_wb),
        .shamt        (shamt),
        .alu_result   (alu_result),
        .st_value_out (st_value_out)
`ifdef ALU_FLAGS_EN
        ,
        .zero_flag    (zero_flag),
        .neg_flag     (neg_flag),
        .ovf_flag     (ovf_flag)
`endif
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] st;
        logic        ovf;
        bit          in_rst;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   clk_en = 0;

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [3:0] c, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [1:0] ss, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] sv, input logic [31:0] m, input logic [31:0] w,
                         input logic [7:0] sh, input logic stl, input logic [31:0] ea,
                         input logic [31:0] es, input logic eo, input string nm,
                         input bit er = 1'b0);
        exp_t e;
        exe_cmd = c; val1_sel = s1; val2_sel = s2; st_val_sel = ss;
        val1 = a1; val2 = a2; st_value_in = sv; alu_res_mem = m; result_wb = w;
        shamt = sh; stall = stl;
        e.alu = ea; e.st = es; e.ovf = eo; e.in_rst = er; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input logic [3:0] c, input logic [1:0] s1, input logic [1:0] s2,
                        input logic [1:0] ss, input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] sv, input logic [31:0] m, input logic [31:0] w,
                        input logic [7:0] sh, input logic stl, input logic [31:0] ea,
                        input logic [31:0] es, input logic eo, input string nm);
        @(negedge clk);
        apply(c, s1, s2, ss, a1, a2, sv, m, w, sh, stl, ea, es, eo, nm);
    endtask

    // Monitor: each queued expectation belongs to the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                #1;
                check({e.name, "/alu"}, alu_result, e.alu);
                check({e.name, "/st"}, st_value_out, e.st);
`ifdef ALU_FLAGS_EN
                check({e.name, "/zf"}, {31'b0, zero_flag}, {31'b0, (!e.in_rst && e.alu == 32'h0)});
                check({e.name, "/nf"}, {31'b0, neg_flag}, {31'b0, e.alu[31]});
                check({e.name, "/of"}, {31'b0, ovf_flag}, {31'b0, e.ovf});
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b1; stall = 1'b0; exe_cmd = EXE_ADD;
        val1_sel = 2'd0; val2_sel = 2'd0; st_val_sel = 2'd0;
        val1 = 32'd5; val2 = 32'd1; st_value_in = 32'h55;
        alu_res_mem = 32'd7; result_wb = 32'd9; shamt = 8'd3;
        #3 rst_n = 1'b0;
        #1;
        check("rst_async/alu", alu_result, 32'h0);
        check("rst_async/st", st_value_out, 32'h0);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold/alu", alu_result, 32'h0);
        check("rst_hold/st", st_value_out, 32'h0);
`ifdef ALU_FLAGS_EN
        check("rst_hold/zf", {31'b0, zero_flag}, 32'h0);
`endif
        rst_n = 1'b1;
        apply(EXE_ADD, 0, 0, 0, 5, 1, 32'h55, 7, 9, 0, 0, 32'd6, 32'h55, 0, "fwd0");

        // forwarding of operand a
        step(EXE_ADD, 1, 0, 0, 5, 1, 32'h55, 7, 9, 0, 0, 32'd8,  32'h55, 0, "fwd1");
        step(EXE_ADD, 2, 0, 0, 5, 1, 32'h55, 7, 9, 0, 0, 32'd10, 32'h55, 0, "fwd2");
        step(EXE_ADD, 3, 0, 0, 5, 1, 32'h55, 7, 9, 0, 0, 32'd1,  32'h55, 0, "fwd3");
        step(EXE_ADD, 2, 2, 0, 5, 1, 32'h55, 7, 9, 0, 0, 32'd18, 32'h55, 0, "same_src");

        // arithmetic and overflow
        step(EXE_SUB, 0, 0, 0, 3, 5, 32'h55, 7, 9, 0, 0, 32'hFFFFFFFE, 32'h55, 0, "sub");
        step(EXE_SLT, 0, 0, 0, 32'hFFFFFFFF, 1, 32'h55, 7, 9, 0, 0, 32'd1, 32'h55, 0, "slt");
        step(EXE_ADD, 0, 0, 0, 32'hFFFFFFFF, 1, 32'h55, 7, 9, 0, 0, 32'h0, 32'h55, 0, "add_wrap");
        step(EXE_ADD, 0, 0, 0, 32'h7FFFFFFF, 1, 32'h55, 7, 9, 0, 0, 32'h80000000, 32'h55, 1, "add_ovf");
        step(EXE_SUB, 0, 0, 0, 32'h80000000, 1, 32'h55, 7, 9, 0, 0, 32'h7FFFFFFF, 32'h55, 1, "sub_ovf");

        // logic ops with b forwarded from EX/MEM
        step(EXE_AND, 0, 1, 0, 32'hF0F0, 0, 32'h55, 32'hFF00, 9, 0, 0, 32'hF000, 32'h55, 0, "and");
        step(EXE_OR,  0, 1, 0, 32'hF0F0, 0, 32'h55, 32'hFF00, 9, 0, 0, 32'hFFF0, 32'h55, 0, "or");
        step(EXE_NOR, 0, 1, 0, 32'hF0F0, 0, 32'h55, 32'hFF00, 9, 0, 0, 32'hFFFF000F, 32'h55, 0, "nor");
        step(EXE_XOR, 0, 1, 0, 32'hF0F0, 0, 32'h55, 32'hFF00, 9, 0, 0, 32'h0FF0, 32'h55, 0, "xor");

        // shifts
        step(EXE_SRA,  0, 0, 0, 0, 32'h80000000, 32'h55, 7, 9, 4,  0, 32'hF8000000, 32'h55, 0, "sra");
        step(EXE_SRL,  0, 0, 0, 0, 32'h80000000, 32'h55, 7, 9, 4,  0, 32'h08000000, 32'h55, 0, "srl");
        step(EXE_SLL,  0, 0, 0, 0, 1,            32'h55, 7, 9, 33, 0, 32'd2,        32'h55, 0, "sll_wrap");
        step(EXE_SLLV, 0, 0, 0, 3, 32'h24,       32'h55, 7, 9, 0,  0, 32'h30,       32'h55, 0, "sllv");

        // store forwarding, then stall with changing inputs
        step(EXE_ADD, 0, 0, 1, 5, 1, 32'hAA, 7, 32'hBB, 0, 0, 32'd6, 32'd7, 0, "st_mem");
        step(EXE_ADD, 0, 0, 3, 5, 1, 32'hAA, 7, 32'hBB, 0, 0, 32'd6, 32'd0, 0, "st_zero");
        step(EXE_ADD, 0, 0, 2, 5, 1, 32'hAA, 7, 32'hBB, 0, 0, 32'd6, 32'hBB, 0, "st_wb");
        step(EXE_SUB, 0, 0, 0, 100, 1, 32'h11, 7, 32'hCC, 0, 1, 32'd6, 32'hBB, 0, "stall1");
        step(EXE_XOR, 1, 1, 1, 3, 9, 32'h22, 32'h1234, 32'hDD, 0, 1, 32'd6, 32'hBB, 0, "stall2");
        step(EXE_ADD, 0, 0, 0, 100, 1, 32'h11, 7, 32'hCC, 0, 0, 32'd101, 32'h11, 0, "unstall");

        // unassigned encodings
        step(4'b1101, 0, 0, 0, 5, 1, 32'h11, 7, 9, 0, 0, 32'h0, 32'h11, 0, "illegal_1101");
        step(4'b0001, 0, 0, 0, 5, 1, 32'h11, 7, 9, 0, 0, 32'h0, 32'h11, 0, "illegal_0001");
        step(EXE_NOP, 0, 0, 0, 5, 1, 32'h11, 7, 9, 0, 0, 32'h0, 32'h11, 0, "nop");

        // reset in flight overrides stall and discards the pending result
        step(EXE_ADD, 0, 0, 0, 40, 2, 32'h33, 7, 9, 0, 0, 32'd42, 32'h33, 0, "pre_rst");
        @(negedge clk);
        apply(EXE_ADD, 0, 0, 0, 5, 1, 32'h44, 7, 9, 0, 1, 32'h0, 32'h0, 0, "rst_mid", 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_async/alu", alu_result, 32'h0);
        check("rst_mid_async/st", st_value_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(EXE_ADD, 0, 0, 0, 2, 3, 32'h66, 7, 9, 0, 0, 32'd5, 32'h66, 0, "after_rst");

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
